fpu_addsub_sequencer: RTL and testbench
=======================================

Name: fpu_addsub_sequencer

Overview:
Multi-cycle controller and datapath sequencer for single-precision FP add/sub on the coprocessor 1 path. It accepts one operand pair per transaction through a valid/ready handshake. It sequences compare/swap, iterative alignment, magnitude add/sub, iterative normalization and pack, then holds the IEEE-754 result until the consumer takes it. It replaces the single-cycle combinational add path where the CPU stalls on `busy`.

Parameters:
ALIGN_STEP, 1, bits shifted right per ALIGN cycle; legal values 1, 2, 4, 8.
FLUSH_DIST, 25, exponent difference at or above which the smaller operand is flushed to zero in one cycle.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start_valid  input  1  operand pair and op presented
start_ready  output  1  block idle; a transaction is accepted on start_valid & start_ready at a rising clk edge
op  input  1  0 = add, 1 = sub (data1 - data2)
data1  input  32  IEEE-754 single operand A
data2  input  32  IEEE-754 single operand B
result_valid  output  1  result held stable
result_ready  input  1  consumer accepts the result
result  output  32  packed IEEE-754 result
zero_flag  output  1  result is ±0
overflow_flag  output  1  exponent saturated to infinity
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (synchronous, active-high, highest priority, valid in any state including mid-transaction): state goes to IDLE. result, zero_flag, overflow_flag and result_valid go to 0; start_ready goes to 1. Any in-flight operation is discarded.
- Operand decode:
  - Exponent 0 means the operand is zero (denormals are flushed).
  - Exponent 255 is out of scope; behaviour is unspecified.
  - Hidden 1 is prepended otherwise.
- States:
  - IDLE: start_ready = 1. On handshake, latch the operands and the effective B sign (sign(data2) XOR op). Compare magnitudes {exp, frac}; swap so that L holds the larger magnitude and S the smaller. Set d = expL - expS. Go to ALIGN.
  - ALIGN: at least 1 cycle.
    - If d >= FLUSH_DIST, S significand = 0 in that single cycle.
    - Otherwise, each cycle shift S right by min(ALIGN_STEP, d) and decrement d by the same amount.
    - Leave when d == 0.
  - ADD: 1 cycle. 25-bit magnitude result.
    - Same signs: sigL + sigS.
    - Different signs: sigL - sigS; this never goes negative because of the swap.
    - Result sign = sign of L. Exponent register = expL.
  - NORM: at least 1 cycle.
    - If carry bit 24 is set: shift right 1, exponent + 1, and finish NORM.
    - Else if the significand is 0: result is +0 and NORM finishes.
    - Else, while bit 23 is clear and exponent > 1: shift left 1 and decrement exponent, one bit per cycle.
    - If bit 23 is still clear when exponent == 1: flush the result to +0 (no denormal output).
  - PACK: 1 cycle.
    - Exponent >= 255: result = {sign, 8'hFF, 23'b0} and overflow_flag = 1.
    - Otherwise result = {sign, exp[7:0], sig[22:0]}.
    - zero_flag = (result[30:0] == 0).
  - DONE: result_valid = 1. Outputs are held stable until result_ready. On result_valid & result_ready, go to IDLE, drop result_valid, and assert start_ready the next cycle.
- Latency from the accept edge to result_valid = A + 1 + N + 1 cycles, where A = ALIGN cycles and N = NORM cycles.
- Ready/valid timing:
  - start_valid is ignored while start_ready = 0.
  - result_ready is ignored while result_valid = 0.
  - No back-to-back overlap: one transaction is in flight at a time.
- Exact cancellation (x - x) always gives +0.
- Exponent arithmetic is 9-bit unsigned internally so increments do not wrap.

Optional Feature:
FPU_STICKY_ROUND_EN.
- Defined: the significand carries guard/round/sticky bits.
  - ALIGN ORs shifted-out bits into sticky; a flush sets sticky if S != 0.
  - A ROUND state is inserted between NORM and PACK, performing round-to-nearest-even.
  - A rounding carry renormalizes with a right shift and exponent + 1, which can set overflow.
  - Latency grows by 1 cycle.
- Undefined: truncation (round toward zero). No GRS bits, no ROUND state.

Decomposition:
- Package fpu_pkg: state enum (IDLE, ALIGN, ADD, NORM, ROUND, PACK, DONE); field widths EXP_W = 8, FRAC_W = 23, SIG_W = 25; constants EXP_MAX = 255, OP_ADD = 0, OP_SUB = 1.
- One sub-module, fpu_align_step: a combinational right shift by 0..ALIGN_STEP that also produces the OR of shifted-out bits for sticky. It is instantiated by the controller.

Test Plan:
1. 0x3F800000 add 0x3F800000 -> result 0x40000000; A = 1, N = 1, result_valid 4 cycles after accept.
2. 0x3FC00000 sub 0x3FC00000 -> result 0x00000000, zero_flag = 1, sign = 0.
3. 0x3F800000 add 0x30800000 (d = 30) -> result 0x3F800000; ALIGN takes exactly 1 cycle (flush).
4. 0x40400000 sub 0x40200000 (3.0 - 2.5) -> result 0x3F000000; N = 2 left-shift cycles.
5. 0x7F7FFFFF add 0x7F7FFFFF -> result 0x7F800000, overflow_flag = 1.
6. Backpressure and reset:
   - Hold result_ready = 0 for 5 cycles in DONE -> result is stable and start_ready = 0; a start_valid pulse during this time is ignored.
   - Separately, assert reset during ALIGN -> next cycle shows IDLE with all outputs 0 and start_ready = 1.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared types and field widths for the single-precision add/sub sequencer.
package fpu_pkg;

    localparam int   EXP_W   = 8;
    localparam int   FRAC_W  = 23;
    localparam int   SIG_W   = 25;
    localparam int   EXP_MAX = 255;
    localparam logic OP_ADD  = 1'b0;
    localparam logic OP_SUB  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        ROUND,
        PACK,
        DONE
    } state_t;

    // Exponent 0 flushes the operand (denormals included) to a zero significand.
    function automatic logic [FRAC_W:0] unpack_sig(input logic [30:0] f);
        if (f[30:FRAC_W] == '0) return '0;
        return {1'b1, f[FRAC_W-1:0]};
    endfunction

endpackage

// File: rtl/fpu_align_step.sv
// Combinational right shift by 0..ALIGN_STEP; o_lost is the OR of the bits shifted out.
module fpu_align_step #(
    parameter int W          = 25,
    parameter int ALIGN_STEP = 1
) (
    input  logic [W-1:0] i_data,
    input  logic [3:0]   i_shamt,
    output logic [W-1:0] o_data,
    output logic         o_lost
);

    logic [3:0]   w_amt;
    logic [W-1:0] w_mask;

    assign w_amt  = (i_shamt > 4'(ALIGN_STEP)) ? 4'(ALIGN_STEP) : i_shamt;
    assign o_data = i_data >> w_amt;
    assign w_mask = ~({W{1'b1}} << w_amt);
    assign o_lost = |(i_data & w_mask);

endmodule

// File: rtl/fpu_addsub_sequencer.sv
// Multi-cycle single-precision add/sub: swap, iterative align, add, iterative normalize, pack.
// Define FPU_STICKY_ROUND_EN for guard/round/sticky bits and a round-to-nearest-even ROUND state.
module fpu_addsub_sequencer
    import fpu_pkg::*;
#(
    parameter int ALIGN_STEP = 1,
    parameter int FLUSH_DIST = 25
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic        op,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    output logic        result_valid,
    input  logic        result_ready,
    output logic [31:0] result,
    output logic        zero_flag,
    output logic        overflow_flag,
    output logic        busy
);

`ifdef FPU_STICKY_ROUND_EN
    localparam int     GRS_W     = 3;
    localparam state_t POST_NORM = ROUND;
`else
    localparam int     GRS_W     = 0;
    localparam state_t POST_NORM = PACK;
`endif
    localparam int W      = SIG_W + GRS_W;
    localparam int HID    = W - 2;
    localparam bit STICKY = (GRS_W > 0);

    state_t       r_state, w_state_nxt;
    logic [W-1:0] r_sig_l, r_sig_s;
    logic [8:0]   r_exp, r_d;
    logic         r_sign_l, r_sign_s;
    logic [31:0]  r_result;
    logic         r_zero, r_ovf;

    logic         w_a_ge_b, w_sign_b_eff;
    logic [W-1:0] w_sig_a, w_sig_b;
    logic [3:0]   w_step;
    logic [8:0]   w_d_nxt;
    logic         w_flush, w_lost, w_norm_done;
    logic [W-1:0] w_shifted;

    assign w_sign_b_eff = data2[31] ^ op;
    assign w_a_ge_b     = data1[30:0] >= data2[30:0];
    assign w_sig_a      = W'({1'b0, unpack_sig(data1[30:0])}) << GRS_W;
    assign w_sig_b      = W'({1'b0, unpack_sig(data2[30:0])}) << GRS_W;

    assign w_step  = (r_d > 9'(ALIGN_STEP)) ? 4'(ALIGN_STEP) : r_d[3:0];
    assign w_d_nxt = r_d - {5'b0, w_step};
    assign w_flush = r_d >= 9'(FLUSH_DIST);

    fpu_align_step #(
        .W          (W),
        .ALIGN_STEP (ALIGN_STEP)
    ) u_align (
        .i_data  (r_sig_s),
        .i_shamt (w_step),
        .o_data  (w_shifted),
        .o_lost  (w_lost)
    );

    // NORM exits once the value about to be written is normalized, zero, or flushed.
    assign w_norm_done = r_sig_l[W-1] || (r_sig_l == '0) || r_sig_l[HID] ||
                         (r_exp <= 9'd1) || r_sig_l[HID-1] || (r_exp == 9'd2);

`ifdef FPU_STICKY_ROUND_EN
    logic             w_rnd_up;
    logic [SIG_W-1:0] w_rnd;
    assign w_rnd_up = r_sig_l[2] & (r_sig_l[1] | r_sig_l[0] | r_sig_l[3]);
    assign w_rnd    = r_sig_l[W-1:GRS_W] + SIG_W'(w_rnd_up);
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start_valid) w_state_nxt = ALIGN;
            ALIGN:   if (w_flush || w_d_nxt == 9'd0) w_state_nxt = ADD;
            ADD:     w_state_nxt = NORM;
            NORM:    if (w_norm_done) w_state_nxt = POST_NORM;
            ROUND:   w_state_nxt = PACK;
            PACK:    w_state_nxt = DONE;
            DONE:    if (result_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sig_l  <= '0;
            r_sig_s  <= '0;
            r_exp    <= '0;
            r_d      <= '0;
            r_sign_l <= 1'b0;
            r_sign_s <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start_valid) begin
                    if (w_a_ge_b) begin
                        r_sig_l  <= w_sig_a;
                        r_sign_l <= data1[31];
                        r_sig_s  <= w_sig_b;
                        r_sign_s <= w_sign_b_eff;
                        r_exp    <= {1'b0, data1[30:23]};
                        r_d      <= {1'b0, data1[30:23]} - {1'b0, data2[30:23]};
                    end else begin
                        r_sig_l  <= w_sig_b;
                        r_sign_l <= w_sign_b_eff;
                        r_sig_s  <= w_sig_a;
                        r_sign_s <= data1[31];
                        r_exp    <= {1'b0, data2[30:23]};
                        r_d      <= {1'b0, data2[30:23]} - {1'b0, data1[30:23]};
                    end
                end
                ALIGN: begin
                    if (w_flush) begin
                        r_sig_s <= W'(STICKY & (|r_sig_s));
                        r_d     <= '0;
                    end else begin
                        r_sig_s <= w_shifted | W'(STICKY & w_lost);
                        r_d     <= w_d_nxt;
                    end
                end
                ADD: begin
                    // The swap guarantees L >= S, so the difference never goes negative.
                    if (r_sign_l == r_sign_s) r_sig_l <= r_sig_l + r_sig_s;
                    else                      r_sig_l <= r_sig_l - r_sig_s;
                end
                NORM: begin
                    if (r_sig_l[W-1]) begin
                        r_sig_l <= (r_sig_l >> 1) | W'(STICKY & r_sig_l[0]);
                        r_exp   <= r_exp + 9'd1;
                    end else if (r_sig_l == '0) begin
                        r_sign_l <= 1'b0;
                        r_exp    <= '0;
                    end else if (!r_sig_l[HID]) begin
                        if (r_exp > 9'd1 && (r_sig_l[HID-1] || r_exp != 9'd2)) begin
                            r_sig_l <= r_sig_l << 1;
                            r_exp   <= r_exp - 9'd1;
                        end else begin
                            r_sig_l  <= '0;
                            r_exp    <= '0;
                            r_sign_l <= 1'b0;
                        end
                    end
                end
`ifdef FPU_STICKY_ROUND_EN
                ROUND: begin
                    if (w_rnd[SIG_W-1]) begin
                        r_sig_l <= W'(w_rnd >> 1) << GRS_W;
                        r_exp   <= r_exp + 9'd1;
                    end else begin
                        r_sig_l <= W'(w_rnd) << GRS_W;
                    end
                end
`endif
                PACK: begin
                    if (r_exp >= 9'(EXP_MAX)) begin
                        r_result <= {r_sign_l, 8'hFF, 23'b0};
                        r_ovf    <= 1'b1;
                        r_zero   <= 1'b0;
                    end else begin
                        r_result <= {r_sign_l, r_exp[7:0], r_sig_l[GRS_W +: FRAC_W]};
                        r_ovf    <= 1'b0;
                        r_zero   <= ({r_exp[7:0], r_sig_l[GRS_W +: FRAC_W]} == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign start_ready   = (r_state == IDLE);
    assign busy          = (r_state != IDLE);
    assign result_valid  = (r_state == DONE);
    assign result        = r_result;
    assign zero_flag     = r_zero;
    assign overflow_flag = r_ovf;

endmodule

// File: tb/tb_fpu_addsub_sequencer.sv
// Directed self-checking bench for fpu_addsub_sequencer with hand-computed results.
module tb_fpu_addsub_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic        op = 1'b0;
    logic [31:0] data1 = '0;
    logic [31:0] data2 = '0;
    logic        result_valid;
    logic        result_ready = 1'b0;
    logic [31:0] result;
    logic        zero_flag;
    logic        overflow_flag;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef FPU_STICKY_ROUND_EN
    localparam int RL = 1;
`else
    localparam int RL = 0;
`endif

    fpu_addsub_sequencer #(.ALIGN_STEP(1), .FLUSH_DIST(25)) dut (
        .clk           (clk),
        .reset         (reset),
        .start_valid   (start_valid),
        .start_ready   (start_ready),
        .op            (op),
        .data1         (data1),
        .data2         (data2),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .result        (result),
        .zero_flag     (zero_flag),
        .overflow_flag (overflow_flag),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one transaction, waits for result_valid, checks it, then consumes it.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic o, input logic [31:0] er, input logic ez,
                          input logic eo, input int elat);
        int lat;
        chk({tag, ".start_ready"}, start_ready, 1);
        data1 = a; data2 = b; op = o; start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        chk({tag, ".busy"}, busy, 1);
        lat = 0;
        while (!result_valid && lat < 200) begin
            tick();
            lat++;
        end
        chk({tag, ".latency"}, lat, elat + RL);
        chk({tag, ".result"}, result, er);
        chk({tag, ".zero"}, zero_flag, ez);
        chk({tag, ".ovf"}, overflow_flag, eo);
        chk({tag, ".ready_in_done"}, start_ready, 0);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk({tag, ".valid_drop"}, result_valid, 0);
        chk({tag, ".ready_back"}, start_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        tick();
        tick();
        reset = 1'b0;
        chk("rst.result", result, 0);
        chk("rst.valid", result_valid, 0);
        chk("rst.start_ready", start_ready, 1);
        chk("rst.busy", busy, 0);
        chk("rst.flags", {zero_flag, overflow_flag}, 0);

        //      tag       data1         data2         op    result        zero  ovf  lat
        run_op("add11",  32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0, 4);
        run_op("cancel", 32'h3FC00000, 32'h3FC00000, 1'b1, 32'h00000000, 1'b1, 1'b0, 4);
        run_op("flush",  32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 4);
        run_op("sub_ls", 32'h40400000, 32'h40200000, 1'b1, 32'h3F000000, 1'b0, 1'b0, 5);
        run_op("sub_ng", 32'h40200000, 32'h40400000, 1'b1, 32'hBF000000, 1'b0, 1'b0, 5);
        run_op("d1",     32'h3F800000, 32'h3F000000, 1'b0, 32'h3FC00000, 1'b0, 1'b0, 4);
        run_op("d3",     32'h3F800000, 32'h3E000000, 1'b0, 32'h3F900000, 1'b0, 1'b0, 6);
        run_op("d24",    32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 27);
        run_op("mixsg",  32'hBF800000, 32'h3F000000, 1'b0, 32'hBF000000, 1'b0, 1'b0, 4);
        run_op("addneg", 32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 1'b1, 1'b0, 4);
        run_op("ovf",    32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b0, 1'b1, 4);

        // Backpressure: result held for 5 cycles, a start pulse in DONE is ignored.
        data1 = 32'h3F800000; data2 = 32'h3F800000; op = 1'b0; start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        lat = 0;
        while (!result_valid && lat < 200) begin
            tick();
            lat++;
        end
        chk("bp.latency", lat, 4 + RL);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                data1 = 32'h40400000; data2 = 32'h40200000; op = 1'b1; start_valid = 1'b1;
            end
            tick();
            start_valid = 1'b0;
            chk($sformatf("bp.result%0d", i), result, 32'h40000000);
            chk($sformatf("bp.valid%0d", i), result_valid, 1);
            chk($sformatf("bp.ready%0d", i), start_ready, 0);
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk("bp.idle_ready", start_ready, 1);
        tick();
        chk("bp.no_ghost", busy, 0);

        // Overflow first so the reset below has nonzero outputs to clear.
        run_op("ovf2", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b0, 1'b1, 4);
        data1 = 32'h3F800000; data2 = 32'h3E000000; op = 1'b0; start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        chk("rstmid.busy_in_align", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstmid.result", result, 0);
        chk("rstmid.valid", result_valid, 0);
        chk("rstmid.flags", {zero_flag, overflow_flag}, 0);
        chk("rstmid.start_ready", start_ready, 1);
        chk("rstmid.busy", busy, 0);
        for (int i = 0; i < 8; i++) tick();
        chk("rstmid.discarded", {result_valid, busy}, 0);

        run_op("post_rst", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
